// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  // Core-side MemWidth codes; fetches always use the word code.
  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

endpackage

// File: rtl/unified_mem_arbiter_mem_wait_timer.sv
// Counts consecutive memory-wait cycles and flags the cycle that reaches TIMEOUT_CYC.
module unified_mem_arbiter_mem_wait_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_r;

  // Wait-cycle counter; clear has priority over counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (count_en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expires on the TIMEOUT_CYC-th waiting cycle, so the abort replaces that cycle's ack.
  assign expire = count_en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and data access (DM).
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module unified_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  input  logic              dm_req_we,
  input  logic [1:0]        dm_req_width,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [1:0]        mem_req_width,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  import unified_mem_arbiter_pkg::*;

  arb_state_e        state_r;
  logic              run_r;
  logic              owner_r;
  logic              mem_req_valid_r;
  logic              mem_req_we_r;
  logic [1:0]        mem_req_width_r;
  logic [ADDR_W-1:0] mem_req_addr_r;
  logic [DATA_W-1:0] mem_req_wdata_r;
  logic              if_rsp_valid_r;
  logic [DATA_W-1:0] if_rsp_data_r;
  logic              dm_rsp_valid_r;
  logic [DATA_W-1:0] dm_rsp_rdata_r;
  logic              rsp_err_r;

  logic busy_s;
  logic count_s;
  logic timer_clear_s;
  logic expire_s;
  logic done_s;
  logic arb_en_s;
  logic if_win_s;
  logic dm_win_s;
  logic force_if_s;

  assign busy_s        = (state_r != ST_IDLE);
  assign count_s       = busy_s && !mem_ack;
  assign timer_clear_s = !count_s || expire_s;
  assign done_s        = busy_s && (mem_ack || expire_s);
  // run_r keeps both ready outputs low while reset is asserted and for the release cycle.
  assign arb_en_s      = run_r && (!busy_s || done_s);

  unified_mem_arbiter_mem_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_mem_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear_s),
    .count_en(count_s),
    .expire  (expire_s)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_r;

  // Counts DM grants taken while a fetch was waiting; any fetch grant clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= {STARVE_W{1'b0}};
    end else if (if_win_s) begin
      starve_cnt_r <= {STARVE_W{1'b0}};
    end else if (dm_win_s && if_req_valid && (starve_cnt_r != STARVE_MAX)) begin
      starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign force_if_s = (starve_cnt_r == STARVE_MAX);
`else
  assign force_if_s = 1'b0;
`endif

  // Priority select: DM wins unless the starvation guard forces a waiting fetch through.
  always_comb begin
    if_win_s = 1'b0;
    dm_win_s = 1'b0;
    if (!arb_en_s) begin
      if_win_s = 1'b0;
      dm_win_s = 1'b0;
    end else if (if_req_valid && (force_if_s || !dm_req_valid)) begin
      if_win_s = 1'b1;
    end else if (dm_req_valid) begin
      dm_win_s = 1'b1;
    end else begin
      if_win_s = 1'b0;
      dm_win_s = 1'b0;
    end
  end

  // Arbiter FSM with registered memory request and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      run_r           <= 1'b0;
      owner_r         <= OWNER_IF;
      mem_req_valid_r <= 1'b0;
      mem_req_we_r    <= 1'b0;
      mem_req_width_r <= 2'b00;
      mem_req_addr_r  <= {ADDR_W{1'b0}};
      mem_req_wdata_r <= {DATA_W{1'b0}};
      if_rsp_valid_r  <= 1'b0;
      if_rsp_data_r   <= {DATA_W{1'b0}};
      dm_rsp_valid_r  <= 1'b0;
      dm_rsp_rdata_r  <= {DATA_W{1'b0}};
      rsp_err_r       <= 1'b0;
    end else begin
      run_r          <= 1'b1;
      if_rsp_valid_r <= 1'b0;
      dm_rsp_valid_r <= 1'b0;
      rsp_err_r      <= 1'b0;

      if (done_s) begin
        rsp_err_r <= expire_s;
        if (state_r == ST_BUSY_IF) begin
          if_rsp_valid_r <= 1'b1;
          if_rsp_data_r  <= expire_s ? {DATA_W{1'b0}} : mem_rdata;
        end else begin
          dm_rsp_valid_r <= 1'b1;
          dm_rsp_rdata_r <= (expire_s || mem_req_we_r) ? {DATA_W{1'b0}} : mem_rdata;
        end
      end

      if (dm_win_s) begin
        state_r         <= ST_BUSY_DM;
        owner_r         <= OWNER_DM;
        mem_req_valid_r <= 1'b1;
        mem_req_we_r    <= dm_req_we;
        mem_req_width_r <= dm_req_width;
        mem_req_addr_r  <= dm_req_addr;
        mem_req_wdata_r <= dm_req_wdata;
      end else if (if_win_s) begin
        state_r         <= ST_BUSY_IF;
        owner_r         <= OWNER_IF;
        mem_req_valid_r <= 1'b1;
        mem_req_we_r    <= 1'b0;
        mem_req_width_r <= MEM_WIDTH_WORD;
        mem_req_addr_r  <= if_req_addr;
        mem_req_wdata_r <= {DATA_W{1'b0}};
      end else if (done_s) begin
        state_r         <= ST_IDLE;
        mem_req_valid_r <= 1'b0;
      end else begin
        state_r         <= state_r;
        mem_req_valid_r <= mem_req_valid_r;
      end
    end
  end

  assign if_req_ready  = if_win_s;
  assign dm_req_ready  = dm_win_s;
  assign if_rsp_valid  = if_rsp_valid_r;
  assign if_rsp_data   = if_rsp_data_r;
  assign dm_rsp_valid  = dm_rsp_valid_r;
  assign dm_rsp_rdata  = dm_rsp_rdata_r;
  assign rsp_err       = rsp_err_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_we    = mem_req_we_r;
  assign mem_req_width = mem_req_width_r;
  assign mem_req_addr  = mem_req_addr_r;
  assign mem_req_wdata = mem_req_wdata_r;
  assign owner         = owner_r;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: expected responses queued at grant, checked by a monitor.
module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  typedef struct packed {
    logic        is_dm;
    logic [31:0] data;
    logic        err;
  } rsp_t;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [5:0] GRANT_SEQ = 6'b101111;
`else
  localparam logic [5:0] GRANT_SEQ = 6'b111111;
`endif

  logic        clk;
  logic        reset;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid;
  logic        dm_req_we;
  logic [1:0]  dm_req_width;
  logic [31:0] dm_req_addr;
  logic [31:0] dm_req_wdata;
  logic        dm_req_ready;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_rdata;
  logic        rsp_err;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [1:0]  mem_req_width;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        owner;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;
  logic [5:0] seq;
  int   hold_cnt;

  unified_mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .dm_req_valid (dm_req_valid),
    .dm_req_we    (dm_req_we),
    .dm_req_width (dm_req_width),
    .dm_req_addr  (dm_req_addr),
    .dm_req_wdata (dm_req_wdata),
    .dm_req_ready (dm_req_ready),
    .dm_rsp_valid (dm_rsp_valid),
    .dm_rsp_rdata (dm_rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_we   (mem_req_we),
    .mem_req_width(mem_req_width),
    .mem_req_addr (mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .owner        (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic d, input logic [31:0] v, input logic e);
    exp_q.push_back({d, v, e});
  endtask

  // Monitor: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (if_rsp_valid || dm_rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got if=%0b dm=%0b with empty scoreboard", if_rsp_valid, dm_rsp_valid);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_port", {30'd0, if_rsp_valid, dm_rsp_valid}, mon_e.is_dm ? 32'd1 : 32'd2);
        check("rsp_data", mon_e.is_dm ? dm_rsp_rdata : if_rsp_data, mon_e.data);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h0;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_width = 2'd0;
    dm_req_addr = 32'h0; dm_req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

    // Reset state with both requesters asserting
    @(negedge clk);
    check("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
    check("rst_dm_ready", {31'd0, dm_req_ready}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd0);
    check("rst_rsp", {29'd0, if_rsp_valid, dm_rsp_valid, rsp_err}, 32'd0);
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // IF only, ack two cycles after accept
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0040;
    #1;
    check("t1_if_ready", {31'd0, if_req_ready}, 32'd1);
    check("t1_dm_ready", {31'd0, dm_req_ready}, 32'd0);
    push_exp(1'b0, 32'h2008_0005, 1'b0);
    @(negedge clk);
    if_req_valid = 1'b0;
    check("t1_mem_valid", {31'd0, mem_req_valid}, 32'd1);
    check("t1_mem_addr", mem_req_addr, 32'h0000_0040);
    check("t1_mem_we", {31'd0, mem_req_we}, 32'd0);
    check("t1_mem_width", {30'd0, mem_req_width}, {30'd0, MEM_WIDTH_WORD});
    check("t1_owner", {31'd0, owner}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    check("t1_no_early_rsp", {31'd0, if_rsp_valid}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    check("t1_rsp_valid", {31'd0, if_rsp_valid}, 32'd1);
    check("t1_mem_idle", {31'd0, mem_req_valid}, 32'd0);

    // Simultaneous IF and DM: DM first, IF granted in the DM ack cycle
    @(negedge clk);
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_width = MEM_WIDTH_HALF; dm_req_addr = 32'h0000_0100;
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0080;
    #1;
    check("t2_dm_ready", {31'd0, dm_req_ready}, 32'd1);
    check("t2_if_ready", {31'd0, if_req_ready}, 32'd0);
    push_exp(1'b1, 32'h1111_2222, 1'b0);
    @(negedge clk);
    dm_req_valid = 1'b0;
    #1;
    check("t2_if_wait", {31'd0, if_req_ready}, 32'd0);
    check("t2_mem_addr", mem_req_addr, 32'h0000_0100);
    check("t2_mem_width", {30'd0, mem_req_width}, {30'd0, MEM_WIDTH_HALF});
    check("t2_owner_dm", {31'd0, owner}, 32'd1);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    check("t2_if_ready_ack", {31'd0, if_req_ready}, 32'd1);
    check("t2_dm_ready_ack", {31'd0, dm_req_ready}, 32'd0);
    push_exp(1'b0, 32'h3333_4444, 1'b0);
    @(negedge clk);
    mem_ack = 1'b0; if_req_valid = 1'b0;
    check("t2_no_idle", {31'd0, mem_req_valid}, 32'd1);
    check("t2_if_addr", mem_req_addr, 32'h0000_0080);
    check("t2_owner_if", {31'd0, owner}, 32'd0);
    check("t2_dm_rsp", {31'd0, dm_rsp_valid}, 32'd1);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    @(negedge clk);
    mem_ack = 1'b0;
    check("t2_if_rsp", {31'd0, if_rsp_valid}, 32'd1);

    // DM byte store, read data must come back as zero
    @(negedge clk);
    dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_width = MEM_WIDTH_BYTE;
    dm_req_addr = 32'h0000_0104; dm_req_wdata = 32'hDEAD_BEEF;
    #1;
    check("t3_dm_ready", {31'd0, dm_req_ready}, 32'd1);
    push_exp(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    dm_req_valid = 1'b0; dm_req_we = 1'b0;
    check("t3_mem_we", {31'd0, mem_req_we}, 32'd1);
    check("t3_mem_wdata", mem_req_wdata, 32'hDEAD_BEEF);
    check("t3_mem_addr", mem_req_addr, 32'h0000_0104);
    check("t3_mem_width", {30'd0, mem_req_width}, {30'd0, MEM_WIDTH_BYTE});
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    mem_ack = 1'b0;
    check("t3_dm_rsp", {31'd0, dm_rsp_valid}, 32'd1);

    // Both continuously valid: grant order depends on the starvation guard
    @(negedge clk);
    seq = GRANT_SEQ;
    dm_req_we = 1'b0; dm_req_width = MEM_WIDTH_WORD; dm_req_addr = 32'h0000_0600;
    if_req_addr = 32'h0000_0700;
    if_req_valid = 1'b1; dm_req_valid = 1'b1;
    for (int g = 0; g < 6; g++) begin
      #1;
      check($sformatf("t4_grant%0d_dm", g), {31'd0, dm_req_ready}, {31'd0, seq[g]});
      check($sformatf("t4_grant%0d_if", g), {31'd0, if_req_ready}, {31'd0, ~seq[g]});
      push_exp(seq[g], 32'h0000_1000 + 32'(g), 1'b0);
      @(negedge clk);
      mem_ack = 1'b0;
      check($sformatf("t4_owner%0d", g), {31'd0, owner}, {31'd0, seq[g]});
      @(negedge clk);
      if (g == 5) begin
        if_req_valid = 1'b0; dm_req_valid = 1'b0;
      end
      mem_ack = 1'b1; mem_rdata = 32'h0000_1000 + 32'(g);
    end
    @(negedge clk);
    mem_ack = 1'b0;

    // Timeout: no ack, abort after TIMEOUT_CYC waiting cycles
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0200; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("t5_if_ready", {31'd0, if_req_ready}, 32'd1);
    push_exp(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    if_req_valid = 1'b0;
    hold_cnt = 0;
    for (int i = 0; i < 80 && mem_req_valid; i++) begin
      hold_cnt++;
      @(negedge clk);
    end
    check("t5_hold_cycles", hold_cnt, 32'd64);
    check("t5_rsp_valid", {31'd0, if_rsp_valid}, 32'd1);
    check("t5_rsp_err", {31'd0, rsp_err}, 32'd1);
    @(negedge clk);
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h0000_0300;
    #1;
    check("t5_next_ready", {31'd0, dm_req_ready}, 32'd1);
    push_exp(1'b1, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    dm_req_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    check("t5_next_rsp", {31'd0, dm_rsp_valid}, 32'd1);

    // Asynchronous reset in the middle of a DM transaction
    @(negedge clk);
    dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_addr = 32'h0000_0400; dm_req_wdata = 32'h1234_5678;
    #1;
    check("t6_dm_ready", {31'd0, dm_req_ready}, 32'd1);
    @(negedge clk);
    check("t6_busy", {31'd0, mem_req_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, mem_req_valid}, 32'd0);
    check("t6_rst_addr", mem_req_addr, 32'd0);
    check("t6_rst_wdata", mem_req_wdata, 32'd0);
    check("t6_rst_ctl", {29'd0, mem_req_we, owner, dm_req_ready}, 32'd0);
    @(negedge clk);
    dm_req_valid = 1'b0; dm_req_we = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t6_idle", {31'd0, mem_req_valid}, 32'd0);
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0500;
    #1;
    check("t6_if_ready", {31'd0, if_req_ready}, 32'd1);
    push_exp(1'b0, 32'h55AA_55AA, 1'b0);
    @(negedge clk);
    if_req_valid = 1'b0;
    check("t6_mem_addr", mem_req_addr, 32'h0000_0500);
    mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
    @(negedge clk);
    mem_ack = 1'b0;
    check("t6_if_rsp", {31'd0, if_rsp_valid}, 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
